// File: rtl/vf_scaler_if.sv
// Sample, command and status bundle between the sine generator/controller and the V/f scaler.
// The slave modport is the scaler side; the master side drives samples and the frequency command.
interface vf_scaler_if #(
    parameter int CH = 3,
    parameter int DW = 7,
    parameter int FW = 7
);
    logic               run;
    logic [FW-1:0]      freq_cmd;
    logic               in_valid;
    logic [CH*DW-1:0]   in_data;
    logic               out_valid;
    logic [CH*DW-1:0]   out_data;
    logic [FW-1:0]      freq_act;
    logic               at_speed;

    modport master (
        output run, freq_cmd, in_valid, in_data,
        input  out_valid, out_data, freq_act, at_speed
    );

    modport slave (
        input  run, freq_cmd, in_valid, in_data,
        output out_valid, out_data, freq_act, at_speed
    );
endinterface

// File: rtl/vf_scaler.sv
// V/f amplitude scaler: slew-limited frequency ramp, boosted/clamped gain, CH samples scaled by gain/F_BASE.
// Latency 3 clocks (S1 capture, S2 multiply, S3 divide); no backpressure, one beat accepted every clock.
module vf_scaler #(
    parameter int CH        = 3,
    parameter int DW        = 7,
    parameter int FW        = 7,
    parameter int F_BASE    = 50,
    parameter int V_BOOST   = 5,
    parameter int RAMP_DIV  = 4,
    parameter int RAMP_STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    vf_scaler_if.slave  bus
);
    localparam int PW = DW + FW;
    localparam int CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(RAMP_DIV - 1);
    localparam logic [FW-1:0] STEP     = FW'(RAMP_STEP);
    localparam logic [FW-1:0] BASE     = FW'(F_BASE);
    localparam logic [FW-1:0] BOOST    = FW'(V_BOOST);
    localparam logic [PW-1:0] DIV      = PW'(F_BASE);

    logic [CW-1:0]          cnt_q, cnt_d;
    logic [FW-1:0]          freq_q, freq_d;
    logic                   at_speed_q, at_speed_d;
    logic [FW-1:0]          tgt, diff, gain;
    logic                   tick;

    logic                   s1_vld_q, s1_vld_d;
    logic [CH*DW-1:0]       s1_dat_q, s1_dat_d;
    logic [FW-1:0]          s1_gain_q, s1_gain_d;
    logic                   s2_vld_q, s2_vld_d;
    logic [CH-1:0][PW-1:0]  s2_prod_q, s2_prod_d;
    logic                   out_vld_q, out_vld_d;
    logic [CH*DW-1:0]       out_dat_q, out_dat_d;

    // Ramp: step toward the effective target once per prescaler wrap, never past it.
    always_comb begin
        tgt    = bus.run ? bus.freq_cmd : '0;
        tick   = (cnt_q == CNT_LAST);
        cnt_d  = tick ? '0 : cnt_q + 1'b1;
        freq_d = freq_q;
        diff   = '0;
        if (tick) begin
            if (freq_q < tgt) begin
                diff   = tgt - freq_q;
                freq_d = freq_q + ((diff > STEP) ? STEP : diff);
            end else if (freq_q > tgt) begin
                diff   = freq_q - tgt;
                freq_d = freq_q - ((diff > STEP) ? STEP : diff);
            end
        end
        at_speed_d = (freq_d == tgt);
    end

    always_comb begin
        if (freq_q == '0) begin
            gain = '0;
        end else if (freq_q < BOOST) begin
            gain = BOOST;
        end else if (freq_q > BASE) begin
            gain = BASE;
        end else begin
            gain = freq_q;
        end
    end

    // Data registers load only on valid beats so out_data holds through bubbles.
    always_comb begin
        s1_vld_d  = bus.in_valid;
        s1_dat_d  = bus.in_valid ? bus.in_data : s1_dat_q;
        s1_gain_d = bus.in_valid ? gain : s1_gain_q;

        s2_vld_d  = s1_vld_q;
        s2_prod_d = s2_prod_q;
        for (int k = 0; k < CH; k++) begin
            if (s1_vld_q) begin
                s2_prod_d[k] = PW'(s1_dat_q[k*DW +: DW]) * PW'(s1_gain_q);
            end
        end

        out_vld_d = s2_vld_q;
        out_dat_d = out_dat_q;
        for (int k = 0; k < CH; k++) begin
            if (s2_vld_q) begin
                out_dat_d[k*DW +: DW] = DW'(s2_prod_q[k] / DIV);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            freq_q     <= '0;
            at_speed_q <= 1'b0;
            s1_vld_q   <= 1'b0;
            s1_dat_q   <= '0;
            s1_gain_q  <= '0;
            s2_vld_q   <= 1'b0;
            s2_prod_q  <= '0;
            out_vld_q  <= 1'b0;
            out_dat_q  <= '0;
        end else begin
            cnt_q      <= cnt_d;
            freq_q     <= freq_d;
            at_speed_q <= at_speed_d;
            s1_vld_q   <= s1_vld_d;
            s1_dat_q   <= s1_dat_d;
            s1_gain_q  <= s1_gain_d;
            s2_vld_q   <= s2_vld_d;
            s2_prod_q  <= s2_prod_d;
            out_vld_q  <= out_vld_d;
            out_dat_q  <= out_dat_d;
        end
    end

    assign bus.out_valid = out_vld_q;
    assign bus.out_data  = out_dat_q;
    assign bus.freq_act  = freq_q;
    assign bus.at_speed  = at_speed_q;
endmodule

// File: tb/tb_vf_scaler.sv
// Directed bench for vf_scaler: default instance for ramp/scaling/pipeline, RAMP_STEP=2 instance for stepping.
module tb_vf_scaler;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_bad;

    vf_scaler_if #(.CH(3), .DW(7), .FW(7)) bus ();
    vf_scaler_if #(.CH(3), .DW(7), .FW(7)) bus2 ();

    vf_scaler u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    vf_scaler #(.RAMP_STEP(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_f1(input logic [6:0] tgt);
        int n;
        n = 0;
        while (bus.freq_act != tgt && n < 600) begin
            tick(1);
            n++;
        end
        chk("ramp_reach", 32'(bus.freq_act), 32'(tgt));
    endtask

    task automatic wait_chg2(input logic [6:0] old, output int n);
        n = 0;
        while (bus2.freq_act == old && n < 10) begin
            tick(1);
            n++;
        end
    endtask

    // One beat presented before the next edge; output expected after the third edge.
    task automatic beat_check(input string tag, input logic [20:0] din, input logic [20:0] exp);
        bus.in_valid = 1'b1;
        bus.in_data  = din;
        tick(1);
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        chk({tag, "_v1"}, 32'(bus.out_valid), 0);
        tick(1);
        chk({tag, "_v2"}, 32'(bus.out_valid), 0);
        tick(1);
        chk({tag, "_v3"}, 32'(bus.out_valid), 1);
        chk({tag, "_dat"}, 32'(bus.out_data), 32'(exp));
        tick(1);
        chk({tag, "_v4"}, 32'(bus.out_valid), 0);
        chk({tag, "_hold"}, 32'(bus.out_data), 32'(exp));
    endtask

    initial begin
        logic [7:0]  pat;
        logic [20:0] exp_dat;
        logic [20:0] last_dat;
        logic [6:0]  c;
        logic [6:0]  prev;
        int          n;
        int          nv;
        int          e;

        n_chk = 0;
        n_bad = 0;
        rst          = 1'b1;
        bus.run      = 1'b1;
        bus.freq_cmd = 7'd10;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus2.run      = 1'b1;
        bus2.freq_cmd = 7'd20;
        bus2.in_valid = 1'b0;
        bus2.in_data  = '0;

        tick(2);
        chk("rst_freq", 32'(bus.freq_act), 0);
        chk("rst_at_speed", 32'(bus.at_speed), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_data", 32'(bus.out_data), 0);
        rst = 1'b0;

        // First ramp tick lands on the 4th edge after release.
        tick(3);
        chk("ramp_e3", 32'(bus.freq_act), 0);
        tick(1);
        chk("ramp_e4", 32'(bus.freq_act), 1);
        tick(35);
        chk("ramp_e39", 32'(bus.freq_act), 9);
        chk("atspd_e39", 32'(bus.at_speed), 0);
        tick(1);
        chk("ramp_e40", 32'(bus.freq_act), 10);
        chk("atspd_e40", 32'(bus.at_speed), 1);
        tick(5);
        chk("atspd_hold", 32'(bus.at_speed), 1);

        bus.freq_cmd = 7'd25;
        wait_f1(7'd25);
        beat_check("f25", {7'd100, 7'd99, 7'd64}, {7'd50, 7'd49, 7'd32});

        bus.freq_cmd = 7'd60;
        wait_f1(7'd60);
        beat_check("clamp", {7'd100, 7'd127, 7'd1}, {7'd100, 7'd127, 7'd1});

        bus.freq_cmd = 7'd2;
        wait_f1(7'd2);
        beat_check("boost", {7'd0, 7'd50, 7'd100}, {7'd0, 7'd5, 7'd10});

        bus.run = 1'b0;
        wait_f1(7'd0);
        chk("stop_atspd", 32'(bus.at_speed), 1);
        beat_check("stop", {7'd100, 7'd127, 7'd1}, 21'd0);

        // Streaming at gain 25/50: every sample halves; bubble at beat 4.
        bus.run      = 1'b1;
        bus.freq_cmd = 7'd25;
        wait_f1(7'd25);
        pat      = 8'b1110_1111;
        last_dat = bus.out_data;
        for (int j = 0; j < 10; j++) begin
            if (j < 8) begin
                c = 7'(10 * j + 3);
                bus.in_valid = pat[j];
                bus.in_data  = pat[j] ? {c + 7'd2, c + 7'd1, c} : {7'h7f, 7'h7f, 7'h7f};
            end else begin
                bus.in_valid = 1'b0;
                bus.in_data  = '0;
            end
            tick(1);
            if (j >= 2) begin
                c = 7'(10 * (j - 2) + 3);
                chk("strm_vld", 32'(bus.out_valid), 32'(pat[j-2]));
                if (pat[j-2]) begin
                    exp_dat  = {(c + 7'd2) >> 1, (c + 7'd1) >> 1, c >> 1};
                    last_dat = exp_dat;
                end
                chk("strm_dat", 32'(bus.out_data), 32'(last_dat));
            end
        end
        tick(1);
        chk("strm_tail", 32'(bus.out_valid), 0);

        // Reset with three beats in flight at 30 Hz.
        bus.freq_cmd = 7'd30;
        wait_f1(7'd30);
        for (int j = 0; j < 3; j++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = {7'd50, 7'd50, 7'd50};
            tick(1);
        end
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        chk("fly_vld", 32'(bus.out_valid), 1);
        chk("fly_dat", 32'(bus.out_data), 32'({7'd30, 7'd30, 7'd30}));
        #2;
        rst = 1'b1;
        #1;
        chk("arst_vld", 32'(bus.out_valid), 0);
        chk("arst_dat", 32'(bus.out_data), 0);
        chk("arst_freq", 32'(bus.freq_act), 0);
        chk("arst_atspd", 32'(bus.at_speed), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        nv = 0;
        for (int j = 0; j < 4; j++) begin
            tick(1);
            nv += int'(bus.out_valid);
            if (j == 2) chk("rerst_e3", 32'(bus.freq_act), 0);
        end
        chk("rerst_e4", 32'(bus.freq_act), 1);
        chk("rerst_novld", 32'(nv), 0);

        // RAMP_STEP = 2 instance.
        n = 0;
        while (bus2.freq_act != 7'd20 && n < 200) begin
            tick(1);
            n++;
        end
        chk("s2_settle", 32'(bus2.freq_act), 20);
        chk("s2_atspd20", 32'(bus2.at_speed), 1);
        bus2.freq_cmd = 7'd17;
        wait_chg2(7'd20, n);
        chk("s2_18", 32'(bus2.freq_act), 18);
        chk("s2_atspd18", 32'(bus2.at_speed), 0);
        wait_chg2(7'd18, n);
        chk("s2_17", 32'(bus2.freq_act), 17);
        chk("s2_gap", 32'(n), 4);
        chk("s2_atspd17", 32'(bus2.at_speed), 1);
        bus2.run = 1'b0;
        prev = 7'd17;
        e    = 15;
        for (int j = 0; j < 9; j++) begin
            wait_chg2(prev, n);
            chk("s2_down", 32'(bus2.freq_act), 32'(e));
            chk("s2_down_atspd", 32'(bus2.at_speed), (e == 0) ? 32'd1 : 32'd0);
            prev = bus2.freq_act;
            e    = (e > 2) ? e - 2 : ((e == 1) ? 0 : 1);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
